pc_file_rd_arb: RTL

PC_FILE_RD_ARB -- requirements
Module: pc_file_rd_arb

---
 rtl/pc_file_rd_arb_if.sv | 38 +++
 rtl/pc_file_rd_arb.sv | 98 +++++++++
 2 files changed

// File: rtl/pc_file_rd_arb_if.sv
// PC file read-arbiter bus.
// Groups the requester side (request valid/address, grant, response) and the
// PC file side (read enable/address/data) of pc_file_rd_arb.
//   IN_flush     mispredict flush
//   IN_req       per-requester read request valid
//   IN_reqAddr   per-requester FetchID to read
//   OUT_grant    one-hot grant (request ready)
//   OUT_pcfRE    PC file read enable
//   OUT_pcfRAddr PC file read address
//   IN_pcfRData  combinational PC file read data
//   OUT_rspValid one-hot response valid, one cycle after grant
//   OUT_rspData  registered read data
// Modport slave is the arbiter; master is its environment.
interface pc_file_rd_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int FID_W   = 5,
  parameter int PCE_W   = 32
);
  logic                           IN_flush;
  logic [NUM_REQ-1:0]             IN_req;
  logic [NUM_REQ-1:0][FID_W-1:0]  IN_reqAddr;
  logic [NUM_REQ-1:0]             OUT_grant;
  logic                           OUT_pcfRE;
  logic [FID_W-1:0]               OUT_pcfRAddr;
  logic [PCE_W-1:0]               IN_pcfRData;
  logic [NUM_REQ-1:0]             OUT_rspValid;
  logic [PCE_W-1:0]               OUT_rspData;

  modport slave (
    input  IN_flush, IN_req, IN_reqAddr, IN_pcfRData,
    output OUT_grant, OUT_pcfRE, OUT_pcfRAddr, OUT_rspValid, OUT_rspData
  );

  modport master (
    output IN_flush, IN_req, IN_reqAddr, IN_pcfRData,
    input  OUT_grant, OUT_pcfRE, OUT_pcfRAddr, OUT_rspValid, OUT_rspData
  );
endinterface

// File: rtl/pc_file_rd_arb.sv
// PC file read-port arbiter.
// Shares one PC file read port among NUM_REQ requesters. Requester 0 has
// fixed priority, requesters 1..NUM_REQ-1 share a round-robin, and any
// requester i>=1 that has lost STARVE_LIM consecutive cycles is boosted ahead
// of requester 0. Read data is registered and returned one cycle after the
// grant, with a one-hot valid naming the requester.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  pc_file_rd_arb_if.slave (requests, grants, PC file port, responses)
module pc_file_rd_arb #(
  parameter int NUM_REQ    = 4,
  parameter int FID_W      = 5,
  parameter int PCE_W      = 32,
  parameter int STARVE_LIM = 7
) (
  input  logic              clk,
  input  logic              rst,
  pc_file_rd_arb_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  logic [IDX_W-1:0]   rrPtr;
  logic [7:0]         waitCnt [1:NUM_REQ-1];
  logic [NUM_REQ-1:0] rspValidQ;
  logic [PCE_W-1:0]   rspDataQ;

  logic               grantAny;
  logic [IDX_W-1:0]   grantIdx;
  logic [NUM_REQ-1:0] grantVec;
  int unsigned        rrIdx;

  // Grant selection: starved requester (lowest index) > requester 0 >
  // round-robin over 1..NUM_REQ-1 starting at rrPtr.
  always_comb begin
    grantAny = 1'b0;
    grantIdx = '0;
    rrIdx    = 1;
    if (!rst && !bus.IN_flush) begin
      for (int unsigned i = 1; i < NUM_REQ; i++) begin
        if (!grantAny && bus.IN_req[IDX_W'(i)] && waitCnt[IDX_W'(i)] >= LIM) begin
          grantAny = 1'b1;
          grantIdx = IDX_W'(i);
        end
      end
      if (!grantAny && bus.IN_req[0]) begin
        grantAny = 1'b1;
        grantIdx = '0;
      end
      for (int unsigned off = 0; off < NUM_REQ - 1; off++) begin
        rrIdx = ((32'(rrPtr) - 1 + off) % (NUM_REQ - 1)) + 1;
        if (!grantAny && bus.IN_req[IDX_W'(rrIdx)]) begin
          grantAny = 1'b1;
          grantIdx = IDX_W'(rrIdx);
        end
      end
    end
  end

  always_comb begin
    grantVec = '0;
    if (grantAny) grantVec = NUM_REQ'(1) << grantIdx;
  end

  assign bus.OUT_grant    = grantVec;
  assign bus.OUT_pcfRE    = grantAny;
  assign bus.OUT_pcfRAddr = grantAny ? bus.IN_reqAddr[grantIdx] : '0;

  // A flush in the response cycle kills the valid combinationally; the data
  // register has already captured the read, so only the valid is masked.
  assign bus.OUT_rspValid = rspValidQ & {NUM_REQ{~(bus.IN_flush | rst)}};
  assign bus.OUT_rspData  = rst ? '0 : rspDataQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr     <= IDX_W'(1);
      rspValidQ <= '0;
      rspDataQ  <= '0;
      for (int unsigned i = 1; i < NUM_REQ; i++) waitCnt[IDX_W'(i)] <= '0;
    end else begin
      rspValidQ <= grantVec;
      if (grantAny) rspDataQ <= bus.IN_pcfRData;
      if (grantAny && grantIdx != '0) begin
        if (grantIdx == IDX_W'(NUM_REQ - 1)) rrPtr <= IDX_W'(1);
        else                                 rrPtr <= grantIdx + IDX_W'(1);
      end
      for (int unsigned i = 1; i < NUM_REQ; i++) begin
        if (bus.IN_flush || !bus.IN_req[IDX_W'(i)] || grantVec[IDX_W'(i)])
          waitCnt[IDX_W'(i)] <= '0;
        else if (waitCnt[IDX_W'(i)] < LIM)
          waitCnt[IDX_W'(i)] <= waitCnt[IDX_W'(i)] + 8'd1;
      end
    end
  end

endmodule
